// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, asynchronous read at the same address.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;

    // The controller only presents addresses already reduced below DEPTH.
    assign idx   = addr[IDX_W-1:0];
    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: clear sweep, wait states, ready handshake, writeback mux.
// Optional DMEM_BOUNDS_CHECK_EN adds mem_fault and drops/zeroes out-of-range accesses.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] alu_result_address,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              memory_to_register,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              mem_busy,
`ifdef DMEM_BOUNDS_CHECK_EN
    output logic              mem_fault,
`endif
    output logic [DATA_W-1:0] output_mux3
);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              mem_ready_q, mem_ready_d;
    logic              mem_busy_q, mem_busy_d;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic              mem_fault_q, mem_fault_d;
    logic              addr_oob;
`endif

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic [ADDR_W:0]   eff_addr_w;
    logic [ADDR_W-1:0] eff_addr;

    assign eff_addr_w = {1'b0, addr_q} % DEPTH_L;
    assign eff_addr   = eff_addr_w[ADDR_W-1:0];
`ifdef DMEM_BOUNDS_CHECK_EN
    assign addr_oob   = ({1'b0, addr_q} >= DEPTH_L);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        clear_ptr_d = clear_ptr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        read_data_d = read_data_q;
        mem_ready_d = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        mem_fault_d = 1'b0;
`endif
        arr_we      = 1'b0;
        arr_addr    = eff_addr;
        arr_wdata   = wdata_q;

        case (state_q)
            CLEAR: begin
                arr_we      = 1'b1;
                arr_addr    = clear_ptr_q;
                arr_wdata   = '0;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (memwrite || memread) begin
                    op_d       = memwrite ? OP_WR : OP_RD;
                    addr_d     = alu_result_address;
                    wdata_d    = write_data;
                    wait_cnt_d = WAIT_INIT;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end else begin
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
`ifdef DMEM_BOUNDS_CHECK_EN
                    mem_fault_d = addr_oob;
                    if (op_q == OP_WR) begin
                        arr_we = !addr_oob;
                    end else begin
                        read_data_d = addr_oob ? '0 : arr_rdata;
                    end
`else
                    if (op_q == OP_WR) begin
                        arr_we = 1'b1;
                    end else begin
                        read_data_d = arr_rdata;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        mem_busy_d = (state_d == CLEAR) || (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            op_q        <= OP_RD;
            clear_ptr_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt_q  <= '0;
            read_data_q <= '0;
            mem_ready_q <= 1'b0;
            mem_busy_q  <= 1'b1;
`ifdef DMEM_BOUNDS_CHECK_EN
            mem_fault_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            clear_ptr_q <= clear_ptr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            read_data_q <= read_data_d;
            mem_ready_q <= mem_ready_d;
            mem_busy_q  <= mem_busy_d;
`ifdef DMEM_BOUNDS_CHECK_EN
            mem_fault_q <= mem_fault_d;
`endif
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign read_data   = read_data_q;
    assign mem_ready   = mem_ready_q;
    assign mem_busy    = mem_busy_q;
`ifdef DMEM_BOUNDS_CHECK_EN
    assign mem_fault   = mem_fault_q;
`endif
    assign output_mux3 = memory_to_register ? read_data_q : alu_result;

endmodule
